// File: rtl/seq_comparator_pkg.sv
// Shared constants and types for the sequential magnitude comparator.
package seq_comparator_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CMP  = 1'b1;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_result_t;

endpackage

// File: rtl/seq_comparator_chunk_cmp.sv
// Combinational magnitude comparator for one CHUNK-bit slice of the operands.
import seq_comparator_pkg::*;

module chunk_cmp #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             ceq,
    output logic             cgt,
    output logic             clt
);

    logic [CHUNK-1:0] bitEq;
    logic [CHUNK-1:0] bitGt;
    logic [CHUNK-1:0] bitLt;

    // One 1-bit comparator per bit position
    for (genvar i = 0; i < CHUNK; i++) begin : gBit
        assign bitEq[i] = ~(a[i] ^ b[i]);
        assign bitGt[i] = a[i] & ~b[i];
        assign bitLt[i] = ~a[i] & b[i];
    end

    assign ceq = &bitEq;

    // Priority chain: scanning upward lets the most significant differing bit decide last
    always_comb begin
        cgt = 1'b0;
        clt = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (!bitEq[i]) begin
                cgt = bitGt[i];
                clt = bitLt[i];
            end
        end
    end

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per clock
// from the MSB chunk down and stops at the first differing chunk.
import seq_comparator_pkg::*;

module seq_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    logic [0:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             smode_q, smode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    cmp_result_t      res_q, res_d;

    logic [WIDTH-1:0] signFlip;
    logic [WIDTH-1:0] aAdj;
    logic [WIDTH-1:0] bAdj;
    logic [WIDTH-1:0] aShift;
    logic [WIDTH-1:0] bShift;
    logic [31:0]      bitBase;
    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic             ceq;
    logic             cgt;
    logic             clt;

    // Offset-binary trick: flipping the sign bit of both operands makes
    // two's-complement ordering match plain unsigned ordering
    assign signFlip = WIDTH'(smode_q) << (WIDTH - 1);
    assign aAdj     = a_q ^ signFlip;
    assign bAdj     = b_q ^ signFlip;

    assign bitBase  = 32'(idx_q) * CHUNK;
    assign aShift   = aAdj >> bitBase;
    assign bShift   = bAdj >> bitBase;
    assign aChunk   = aShift[CHUNK-1:0];
    assign bChunk   = bShift[CHUNK-1:0];

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) uChunkCmp (
        .a   (aChunk),
        .b   (bChunk),
        .ceq (ceq),
        .cgt (cgt),
        .clt (clt)
    );

    // Next-state logic: accept a request in IDLE, step through chunks in CMP
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        smode_d = smode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    smode_d = signed_mode;
                    idx_d   = LAST_IDX;
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!ceq) begin
                    res_d   = '{eq: 1'b0, gt: cgt, lt: clt};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    res_d   = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any comparison in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            smode_q <= MODE_UNSIGNED;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            smode_q <= smode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = res_q.eq;
    assign gt   = res_q.gt;
    assign lt   = res_q.lt;

endmodule
